// File: rtl/riscv_v_csr_ctrl.sv
// Vector CSR sequencer: runs vsetvl/vsetvli and Zicsr accesses, owns the single
// CSR write port per cycle and folds execution-side saturation events into vxsat.
module riscv_v_csr_ctrl #(
    parameter int VLEN = 128,
    parameter int XLEN = 32,
    parameter int VL_W = $clog2(VLEN/8)+1
) (
    input  logic            clk,
    input  logic            rst,
    input  logic            vset_valid,
    output logic            vset_ready,
    input  logic [XLEN-1:0] vset_avl,
    input  logic [7:0]      vset_vtype,
    input  logic            csr_valid,
    output logic            csr_ready,
    input  logic [11:0]     csr_addr,
    input  logic [1:0]      csr_op,
    input  logic [XLEN-1:0] csr_wdata,
    output logic            rsp_valid,
    input  logic            rsp_ready,
    output logic [XLEN-1:0] rsp_rdata,
    output logic            rsp_err,
    input  logic            vxsat_set,
    input  logic [XLEN-1:0] vtype_q,
    input  logic [VL_W-1:0] vl_q,
    input  logic [VL_W-1:0] vstart_q,
    input  logic [1:0]      vxrm_q,
    input  logic            vxsat_q,
    output logic            vtype_wr_en,
    output logic [XLEN-1:0] vtype_wdata,
    output logic            vl_wr_en,
    output logic [VL_W-1:0] vl_wdata,
    output logic            vstart_wr_en,
    output logic [VL_W-1:0] vstart_wdata,
    output logic            vxrm_wr_en,
    output logic [1:0]      vxrm_wdata,
    output logic            vxsat_wr_en,
    output logic            vxsat_wdata,
    output logic            busy
);

    localparam logic [1:0] ST_IDLE    = 2'd0;
    localparam logic [1:0] ST_VSET_WR = 2'd1;
    localparam logic [1:0] ST_CSR_WR  = 2'd2;
    localparam logic [1:0] ST_RESP    = 2'd3;

    localparam logic [1:0] OP_RW = 2'b01;
    localparam logic [1:0] OP_RS = 2'b10;
    localparam logic [1:0] OP_RC = 2'b11;

    localparam logic [XLEN-1:0] VLENB = XLEN'(VLEN/8);

    logic [1:0]      state_q, state_d;
    logic [XLEN-1:0] req_data_q, req_data_d;
    logic [7:0]      req_vtype_q, req_vtype_d;
    logic [11:0]     req_addr_q, req_addr_d;
    logic [1:0]      req_op_q, req_op_d;
    logic [XLEN-1:0] rdata_q, rdata_d;
    logic            err_q, err_d;
    logic            sat_pending_q, sat_pending_d;

    logic [2:0]      vsew;
    logic [XLEN-1:0] vlmax, vl_calc;
    logic            vtype_legal;

    always_comb begin
        vsew        = req_vtype_q[5:3];
        vlmax       = XLEN'(VLEN) >> (32'd3 + 32'(vsew));
        vtype_legal = (req_vtype_q[2:0] == 3'b000) && (vsew <= 3'd2) && (vlmax != '0);
        vl_calc     = '0;
        if (vtype_legal) vl_calc = (req_data_q < vlmax) ? req_data_q : vlmax;
    end

    logic [XLEN-1:0] csr_old, csr_new, field_mask;
    logic            csr_mapped, csr_ro, csr_err;

    always_comb begin
        csr_old    = '0;
        field_mask = '0;
        csr_mapped = 1'b1;
        csr_ro     = 1'b0;
        case (req_addr_q)
            12'h008: begin csr_old = XLEN'(vstart_q); field_mask = XLEN'({VL_W{1'b1}}); end
            12'h009: begin csr_old = XLEN'(vxsat_q);  field_mask = XLEN'(1); end
            12'h00A: begin csr_old = XLEN'(vxrm_q);   field_mask = XLEN'(3); end
            12'h00F: begin csr_old = XLEN'({vxrm_q, vxsat_q}); field_mask = XLEN'(7); end
            12'hC20: begin csr_old = XLEN'(vl_q); csr_ro = 1'b1; end
            12'hC21: begin csr_old = vtype_q;     csr_ro = 1'b1; end
            12'hC22: begin csr_old = VLENB;       csr_ro = 1'b1; end
            default: csr_mapped = 1'b0;
        endcase
        case (req_op_q)
            OP_RW:   csr_new = req_data_q;
            OP_RS:   csr_new = csr_old | req_data_q;
            OP_RC:   csr_new = csr_old & ~req_data_q;
            default: csr_new = '0;
        endcase
        csr_new = csr_new & field_mask;
        // Read-only CSRs tolerate RS/RC with a zero operand: that is a pure read.
        csr_err = (req_op_q == 2'b00) || !csr_mapped ||
                  (csr_ro && ((req_op_q == OP_RW) || (req_data_q != '0)));
    end

    always_comb begin
        state_d       = state_q;
        req_data_d    = req_data_q;
        req_vtype_d   = req_vtype_q;
        req_addr_d    = req_addr_q;
        req_op_d      = req_op_q;
        rdata_d       = rdata_q;
        err_d         = err_q;
        vset_ready    = 1'b0;
        csr_ready     = 1'b0;
        rsp_valid     = 1'b0;
        rsp_rdata     = '0;
        rsp_err       = 1'b0;
        vtype_wr_en   = 1'b0;
        vtype_wdata   = '0;
        vl_wr_en      = 1'b0;
        vl_wdata      = '0;
        vstart_wr_en  = 1'b0;
        vstart_wdata  = '0;
        vxrm_wr_en    = 1'b0;
        vxrm_wdata    = '0;
        vxsat_wr_en   = 1'b0;
        vxsat_wdata   = 1'b0;
        case (state_q)
            ST_IDLE: begin
                vset_ready = 1'b1;
                csr_ready  = !vset_valid;
                if (vset_valid) begin
                    req_data_d  = vset_avl;
                    req_vtype_d = vset_vtype;
                    state_d     = ST_VSET_WR;
                end else if (csr_valid) begin
                    req_data_d = csr_wdata;
                    req_addr_d = csr_addr;
                    req_op_d   = csr_op;
                    state_d    = ST_CSR_WR;
                end
            end
            ST_VSET_WR: begin
                vl_wr_en     = 1'b1;
                vl_wdata     = vl_calc[VL_W-1:0];
                vtype_wr_en  = 1'b1;
                vtype_wdata  = vtype_legal ? XLEN'(req_vtype_q) : {1'b1, {(XLEN-1){1'b0}}};
                vstart_wr_en = 1'b1;
                rdata_d      = vl_calc;
                err_d        = 1'b0;
                state_d      = ST_RESP;
            end
            ST_CSR_WR: begin
                rdata_d = csr_old;
                err_d   = csr_err;
                if (!csr_err && !csr_ro) begin
                    case (req_addr_q)
                        12'h008: begin vstart_wr_en = 1'b1; vstart_wdata = csr_new[VL_W-1:0]; end
                        12'h009: begin vxsat_wr_en = 1'b1; vxsat_wdata = csr_new[0]; end
                        12'h00A: begin vxrm_wr_en = 1'b1; vxrm_wdata = csr_new[1:0]; end
                        12'h00F: begin
                            vxrm_wr_en  = 1'b1;
                            vxrm_wdata  = csr_new[2:1];
                            vxsat_wr_en = 1'b1;
                            vxsat_wdata = csr_new[0];
                        end
                        default: ;
                    endcase
                end
                state_d = ST_RESP;
            end
            default: begin
                rsp_valid = 1'b1;
                rsp_rdata = rdata_q;
                rsp_err   = err_q;
                if (rsp_ready) state_d = ST_IDLE;
            end
        endcase
        // A software vxsat write this cycle wins; the pending event lands next cycle.
        sat_pending_d = sat_pending_q | vxsat_set;
        if (sat_pending_q && !vxsat_wr_en) begin
            vxsat_wr_en   = 1'b1;
            vxsat_wdata   = 1'b1;
            sat_pending_d = vxsat_set;
        end
        busy = (state_q != ST_IDLE) || sat_pending_q;
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q       <= ST_IDLE;
            req_data_q    <= '0;
            req_vtype_q   <= '0;
            req_addr_q    <= '0;
            req_op_q      <= '0;
            rdata_q       <= '0;
            err_q         <= 1'b0;
            sat_pending_q <= 1'b0;
        end else begin
            state_q       <= state_d;
            req_data_q    <= req_data_d;
            req_vtype_q   <= req_vtype_d;
            req_addr_q    <= req_addr_d;
            req_op_q      <= req_op_d;
            rdata_q       <= rdata_d;
            err_q         <= err_d;
            sat_pending_q <= sat_pending_d;
        end
    end

endmodule

// File: doc/riscv_v_csr_ctrl.md
Name: riscv_v_csr_ctrl

Overview:
- Sequencer and write arbiter in front of the vector CSR register file.
- Executes vsetvl/vsetvli requests: computes vl from AVL and vtype, flags illegal vtype (vill), clears vstart.
- Executes scalar Zicsr accesses (RW/RS/RC) to vector CSRs.
- Merges asynchronous saturation events from the vector execution unit into vxsat.
- Exactly one CSR write source owns the register file in any cycle.

Parameters:
- VLEN, 128, vector register length in bits.
- XLEN, 32, scalar data width.
- VL_W, $clog2(VLEN/8)+1, width of vl/avl-derived fields.

Ports:
- clk  in  1  clock
- rst  in  1  reset, asynchronous, active-high
- vset_valid  in  1  vset request valid
- vset_ready  out  1  vset request accepted
- vset_avl  in  XLEN  requested application vector length
- vset_vtype  in  8  {vma,vta,vsew[2:0],vlmul[2:0]}
- csr_valid  in  1  Zicsr request valid
- csr_ready  out  1  Zicsr request accepted
- csr_addr  in  12  CSR address
- csr_op  in  2  01=RW, 10=RS, 11=RC, 00=illegal
- csr_wdata  in  XLEN  operand
- rsp_valid  out  1  response valid (vset or csr)
- rsp_ready  in  1  response consumed
- rsp_rdata  out  XLEN  new vl (vset) / old CSR value (csr)
- rsp_err  out  1  illegal access
- vxsat_set  in  1  saturation event pulse from execution
- vtype_q, vl_q, vstart_q, vxrm_q, vxsat_q  in  XLEN,VL_W,VL_W,2,1  current CSR values
- vtype_wr_en/vtype_wdata, vl_wr_en/vl_wdata, vstart_wr_en/vstart_wdata, vxrm_wr_en/vxrm_wdata, vxsat_wr_en/vxsat_wdata  out  1 + matching width  CSR write ports
- busy  out  1  FSM not IDLE or saturation event pending

Behaviour:
- Reset: FSM=IDLE, sat_pending=0, every output 0 except vset_ready=1 and csr_ready=1.
- FSM states: IDLE, VSET_WR, CSR_WR, RESP.
- IDLE:
  - vset_ready=1; csr_ready=!vset_valid, so vset has priority.
  - Accepted vset → VSET_WR. Accepted csr → CSR_WR. Request fields are latched on acceptance.
- VSET_WR (exactly one cycle) → RESP:
  - vtype is legal iff vlmul==000, vsew<=010, and VLEN>>(3+vsew)>=1.
  - vlmax = VLEN>>(3+vsew).
  - Legal: vl = min(avl, vlmax); vtype_wdata = zero-extended vtype.
  - Illegal: vl = 0; vtype_wdata = {1'b1 (vill, bit XLEN-1), zeros}; rsp_err=0 (vill is architectural, not an error).
  - vl_wr_en, vtype_wr_en and vstart_wr_en (data 0) all assert this cycle.
  - rsp_rdata = computed vl.
- CSR_WR (exactly one cycle) → RESP:
  - Address map: 0x008 vstart, 0x009 vxsat, 0x00A vxrm, 0x00F vcsr {vxrm,vxsat} in bits [2:0], 0xC20 vl, 0xC21 vtype, 0xC22 vlenb (= VLEN/8).
  - rsp_rdata = old value, zero-extended.
  - new = RW: wdata; RS: old|wdata; RC: old&~wdata. Truncate to the field width.
  - A vcsr write drives vxrm_wr_en and vxsat_wr_en together.
  - Set rsp_err=1 and suppress all writes for: a write to 0xC20–0xC22, op==00, or an unmapped address.
  - Reads of 0xC2x with RS/RC and wdata==0 are legal, with no write.
- RESP: rsp_valid=1 with stable rdata/err until rsp_ready; then → IDLE. The request ports are not ready in RESP.
- Latency: accept at cycle N, write at N+1, rsp_valid at N+2. Back-to-back throughput is one request per 3 cycles.
- Saturation events:
  - vxsat_set sets sat_pending in any state.
  - While sat_pending=1 and no CSR_WR write to vxsat occurs this cycle: vxsat_wr_en=1, vxsat_wdata=1, sat_pending cleared next cycle. A vxsat_set arriving in that same flush cycle keeps it set.
  - On collision with a CSR_WR write to vxsat, the CSR write wins. Pending stays and flushes the following cycle, so the saturation lands after the clear.
- Reset mid-operation: abort immediately, drop the latched request and any pending saturation, no write pulses.
- Write enables are single-cycle pulses and are never asserted in IDLE or RESP, except the vxsat flush.

Test Plan:
- vset avl=5, vtype=0x10 (sew=32, lmul=1, VLEN=128): expect vlmax=4, vl_wdata=4, vtype_wdata=0x10, vstart_wr_en with 0, rsp_rdata=4 at cycle N+2.
- vset vtype vlmul=001 or vsew=011: expect vl_wdata=0, vtype_wdata=0x80000000, rsp_err=0.
- csr RS to 0x00F with vcsr=3'b010, wdata=0x1: expect rdata=0x2, vxrm_wdata=01, vxsat_wdata=1. csr RW to 0xC20: expect rsp_err=1 and no write pulses.
- vxsat_set pulsed in the same cycle as a CSR_WR RC clearing vxsat: expect vxsat_wdata=0 that cycle, then vxsat_wr_en with data 1 the next cycle, busy=1 until the flush.
- vset_valid and csr_valid asserted together in IDLE: expect csr_ready=0, vset served first, csr accepted after the RESP handshake. Hold rsp_ready=0 for 5 cycles: rsp_valid and rsp_rdata stay stable.
- Assert rst during VSET_WR: no vl/vtype write pulse, FSM=IDLE, rsp_valid=0, sat_pending=0 after reset release.
